// File: rtl/display_scan_driver.sv
// ============================================================================
// Module   : display_scan_driver
// Purpose  : Multiplexed seven-segment scan driver with per-digit PWM
//            brightness, decimal points, blanking and a double-buffered digit
//            store. Optional macro DISPLAY_LEADING_ZERO_BLANK_EN enables
//            leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 2500,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                      qzt_clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      load,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [7:0]                element,
    output logic                      frame_done
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]          c_presc_last = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]          c_idx_last   = IW'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_BITS-1:0] c_sub_last   = '1;
    localparam logic [NUM_DIGITS-1:0]  c_one_hot0   = NUM_DIGITS'(1);

    logic [PW-1:0]           r_presc;
    logic [BRIGHT_BITS-1:0]  r_sub;
    logic [IW-1:0]           r_idx;

    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [4*NUM_DIGITS-1:0] r_pend_digits;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_valid;

    logic                    w_sub_tick;
    logic                    w_sub_wrap;
    logic                    w_frame_wrap;
    logic [3:0]              w_nibbles [NUM_DIGITS];
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic                    w_on;
    logic [6:0]              w_seg;

    assign w_sub_tick   = (r_presc == c_presc_last);
    assign w_sub_wrap   = w_sub_tick && (r_sub == c_sub_last);
    assign w_frame_wrap = w_sub_wrap && (r_idx == c_idx_last);

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
            assign w_nibbles[k] = r_act_digits[4*k +: 4];
        end
    endgenerate

    assign w_nib = w_nibbles[r_idx];

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lz;

    // Suppression runs from the most significant digit downward and stops at
    // the first non-zero nibble or set decimal point; digit 0 always shows.
    always_comb begin
        logic run;
        w_lz = '0;
        run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run   = run && (w_nibbles[k] == 4'h0) && !r_act_dp[k];
            w_lz[k] = run;
        end
    end

    assign w_blank = r_act_blank[r_idx] | w_lz[r_idx];
`else
    assign w_blank = r_act_blank[r_idx];
`endif

    assign w_on = !w_blank && (r_sub <= brightness);

    // Active-high gfedcba patterns; inverted when registered onto element.
    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            4'hF: w_seg = 7'h71;
            default: w_seg = 7'h00;
        endcase
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc       <= '0;
            r_sub         <= '0;
            r_idx         <= '0;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
            r_act_blank   <= '0;
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_pend_valid  <= 1'b0;
            anode         <= '1;
            element       <= 8'hFF;
            frame_done    <= 1'b0;
        end else begin
            r_presc <= w_sub_tick ? '0 : r_presc + 1'b1;

            if (w_sub_tick) begin
                r_sub <= r_sub + 1'b1;
                if (w_sub_wrap) begin
                    r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                end
            end

            frame_done <= w_frame_wrap;

            if (load) begin
                r_pend_digits <= digits_in;
                r_pend_dp     <= dp_in;
                r_pend_blank  <= blank_in;
            end

            // A load on the wrap cycle is newer than anything pending, so it
            // bypasses the pending buffer entirely.
            if (w_frame_wrap && load) begin
                r_act_digits <= digits_in;
                r_act_dp     <= dp_in;
                r_act_blank  <= blank_in;
                r_pend_valid <= 1'b0;
            end else if (w_frame_wrap && r_pend_valid) begin
                r_act_digits <= r_pend_digits;
                r_act_dp     <= r_pend_dp;
                r_act_blank  <= r_pend_blank;
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_valid <= 1'b1;
            end

            anode   <= w_on ? ~(c_one_hot0 << r_idx) : '1;
            element <= w_on ? {~r_act_dp[r_idx], ~w_seg} : 8'hFF;
        end
    end

endmodule

`default_nettype wire

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 2500: qzt_clk cycles per sub-tick, legal minimum 2.
REQ-003 Parameter BRIGHT_BITS, default 4: brightness resolution; each digit slot contains 2^BRIGHT_BITS sub-ticks.
REQ-004 qzt_clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 digits_in  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, and digit 0 is least significant.
REQ-007 dp_in  in  NUM_DIGITS  decimal-point enables, one per digit.
REQ-008 blank_in  in  NUM_DIGITS  per-digit force-blank.
REQ-009 load  in  1  one-cycle strobe that captures digits_in, dp_in and blank_in into the pending buffer.
REQ-010 brightness  in  BRIGHT_BITS  duty level, sampled live.
REQ-011 anode  out  NUM_DIGITS  active-low digit enables.
REQ-012 element  out  8  active-low segments, bit order g..a in [6:0] and dp in [7].
REQ-013 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-014 A prescaler shall count 0..SCAN_DIV-1 and wrap to 0; sub_tick is asserted on the cycle the count equals SCAN_DIV-1.
REQ-015 A sub counter (BRIGHT_BITS wide) shall increment on each sub_tick and wrap from 2^BRIGHT_BITS-1 to 0.
REQ-016 A digit index shall advance on a sub_tick that wraps the sub counter, and shall wrap from NUM_DIGITS-1 to 0.
REQ-017 frame_done shall be high for exactly the one cycle after the index wraps to 0.
REQ-018 The displayed digit shall be the one at the current index; its anode bit is 0 only while sub <= brightness and the digit is not blanked; all other anode bits shall be 1.
REQ-019 Brightness 2^BRIGHT_BITS-1 gives 100% duty; brightness 0 gives a 1/2^BRIGHT_BITS duty.
REQ-020 Segment decode shall be full hex 0-F in standard seven-segment patterns: A=77h, b=7Ch, C=39h, d=5Eh, E=79h, F=71h, shown active-high, with the outputs inverted.
REQ-021 element[7] shall be 0 when the active dp bit is set and the digit is displayed.
REQ-022 When the digit is blanked or its anode is off, element shall be FFh.
REQ-023 anode and element shall be registered, one cycle after the index, sub counter and buffer state they reflect; they shall never show a mix of two digits in the same cycle.
REQ-024 Double buffering: load writes the pending buffer and sets pending_valid. At the frame wrap, if pending_valid is set, the pending buffer is copied to the active buffer and pending_valid is cleared.
REQ-025 When several loads occur within one frame, the last one wins.
REQ-026 When load coincides with the frame-wrap cycle, the new input data shall go directly to the active buffer and pending_valid shall remain clear.
REQ-027 Without a load, the active buffer shall hold indefinitely.

Reset
REQ-028 While reset_n=0: anode shall be all ones, element FFh and frame_done 0.
REQ-029 While reset_n=0: the prescaler, sub counter and index shall be 0, the active and pending buffers zero, and pending_valid 0.
REQ-030 Reset asserted mid-frame shall take effect immediately and asynchronously.
REQ-031 After reset_n deasserts, scanning shall restart at digit 0 and sub 0, and the display shall show "0" on all digits at the given brightness until the first transfer.

Configuration
REQ-032 With macro DISPLAY_LEADING_ZERO_BLANK_EN defined, digits NUM_DIGITS-1 down to 1 shall be blanked while they and all more significant active nibbles are 0 and their dp bit is clear; digit 0 shall never be suppressed.
REQ-033 Without DISPLAY_LEADING_ZERO_BLANK_EN, no suppression logic shall be synthesised and every non-blanked digit shall be displayed.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BRIGHT_BITS=2)
REQ-034 Reset release, then load 4321h with brightness=3 -> after the next frame_done, each anode is low for 16 cycles in sequence 1110,1101,1011,0111, with element F9h ("1") on digit 0 and the frame period 64 cycles.
REQ-035 brightness=1 with the same data -> each anode is low for 8 of its 16 cycles (sub 0,1) and element is FFh for the remaining 8.
REQ-036 Load 00A5h, dp_in=0010b and blank_in=1000b -> digit 0 shows 92h, digit 1 shows 08h ("A" with dp), and digit 3's anode stays 1 all frame.
REQ-037 Loads of 1111h then 2222h mid-frame, plus a load of 3333h on the wrap cycle -> the next frame shows 3333h, and neither 1111h nor 2222h is ever displayed.
REQ-038 With DISPLAY_LEADING_ZERO_BLANK_EN defined, load 0007h -> digits 3..1 are blank and digit 0 shows F8h; load 0000h -> only digit 0 shows C0h.
REQ-039 Assert reset_n=0 during digit 2 -> anode goes to 1111b and element to FFh in the same cycle without a clock edge; after release, scanning restarts at digit 0.
